// File: rtl/dmux_stream_nway.sv
// Registered, handshaked N-way stream demultiplexer.
// A single producer feeds N independent consumers. Each channel owns a
// one-entry output register. Words go to one channel (unicast), to all
// channels (broadcast, all-or-nothing), or are discarded with a one-cycle
// drop pulse when the select is out of range.

// One output channel: a single-entry register with valid/ready drain.
module dmux_stream_chan #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    // A load wins over a drain, so drain+load in one cycle keeps the channel full.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Channel state; reset empties the channel without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

module dmux_stream_nway #(
    parameter  int WIDTH = 16,
    parameter  int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_bcast,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic               drop,
    output logic               busy
);

    // N widened by one bit so the range compare works for power-of-2 N too.
    localparam logic [SEL_W:0] N_L = (SEL_W+1)'(N);

    logic [N-1:0]            hit;
    logic [N-1:0]            free;
    logic [N-1:0]            load;
    logic [N-1:0][WIDTH-1:0] ch_data;
    logic                    sel_oor;
    logic                    xfer;
    logic                    drop_q, drop_d;

    // One-hot decode of the select; an out-of-range select decodes to zero.
    always_comb begin
        hit = '0;
        for (int i = 0; i < N; i++) begin
            hit[i] = (in_sel == SEL_W'(i));
        end
    end

    assign sel_oor = ({1'b0, in_sel} >= N_L);

    // A channel can take a word if empty or being drained this cycle.
    assign free = ~out_valid | out_ready;

    // Accept decision never looks at in_valid; held low through reset.
    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            if (in_bcast)     in_ready = &free;
            else if (sel_oor) in_ready = 1'b1;
            else              in_ready = |(hit & free);
        end
    end

    assign xfer = in_valid & in_ready;

    // Broadcast loads every channel at once; unicast only the decoded one.
    always_comb begin
        load = '0;
        if (xfer) begin
            if (in_bcast) load = '1;
            else          load = hit;
        end
    end

    assign drop_d = xfer & ~in_bcast & sel_oor;

    // Drop pulse lasts exactly the cycle after the discarded word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_q <= 1'b0;
        else        drop_q <= drop_d;
    end

    for (genvar g = 0; g < N; g++) begin : g_chan
        dmux_stream_chan #(.WIDTH(WIDTH)) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (load[g]),
            .data_i  (in_data),
            .ready_i (out_ready[g]),
            .valid_o (out_valid[g]),
            .data_o  (ch_data[g])
        );
    end

    assign out_data = ch_data;
    assign drop     = drop_q;
    assign busy     = |out_valid;

endmodule

// File: tb/tb_dmux_stream_nway.sv
// Bench for dmux_stream_nway: a 4-channel instance checked by a scoreboard
// plus directed checks, and a 3-channel instance for the out-of-range drop.
module tb_dmux_stream_nway;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_valid3;
    logic        in_ready, in_ready3;
    logic [15:0] in_data;
    logic [1:0]  in_sel;
    logic        in_bcast;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [63:0] out_data;
    logic        drop, busy;
    logic [2:0]  out_valid3;
    logic [2:0]  out_ready3;
    logic [47:0] out_data3;
    logic        drop3, busy3;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]  ch;
        logic [15:0] d;
    } sb_t;
    sb_t sb[$];

    always #5 clk = ~clk;

    dmux_stream_nway #(.WIDTH(16), .N(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .drop(drop), .busy(busy)
    );

    dmux_stream_nway #(.WIDTH(16), .N(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_data(in_data), .in_sel(in_sel), .in_bcast(1'b0),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .drop(drop3), .busy(busy3)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop on each drain, push on each accept (inputs are stable here).
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    int   idx;
                    logic found;
                    idx   = 0;
                    found = 1'b0;
                    for (int j = 0; j < sb.size(); j++) begin
                        if (!found && sb[j].ch == 2'(i)) begin
                            found = 1'b1;
                            idx   = j;
                        end
                    end
                    chk("sb_found", {63'd0, found}, 64'd1);
                    if (found) begin
                        chk($sformatf("sb_ch%0d", i), {48'd0, out_data[i*16 +: 16]}, {48'd0, sb[idx].d});
                        sb.delete(idx);
                    end
                end
            end
            if (in_valid && in_ready) begin
                if (in_bcast) begin
                    for (int i = 0; i < 4; i++) sb.push_back('{ch: 2'(i), d: in_data});
                end else begin
                    sb.push_back('{ch: in_sel, d: in_data});
                end
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        in_valid3  = 1'b0;
        in_data    = 16'h5555;
        in_sel     = 2'd0;
        in_bcast   = 1'b0;
        out_ready  = 4'b0000;
        out_ready3 = 3'b000;

        // Reset holds everything idle even with in_valid high.
        tick();
        tick();
        chk("rst_out_valid", {60'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_drop", {63'd0, drop}, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk("rel_in_ready", {63'd0, in_ready}, 64'd1);

        // Unicast to channel 2, then back-pressure on a second word.
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        in_sel   = 2'd2;
        tick();
        chk("uni_valid", {60'd0, out_valid}, 64'h4);
        chk("uni_data", {48'd0, out_data[47:32]}, 64'hBEEF);
        chk("uni_busy", {63'd0, busy}, 64'd1);
        in_data = 16'hCAFE;
        #1;
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        chk("stall_in_ready2", {63'd0, in_ready}, 64'd0);
        chk("stall_data", {48'd0, out_data[47:32]}, 64'hBEEF);
        out_ready = 4'b0100;
        #1;
        chk("drain_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        chk("reload_valid", {60'd0, out_valid}, 64'h4);
        chk("reload_data", {48'd0, out_data[47:32]}, 64'hCAFE);
        tick();
        chk("drained_valid", {60'd0, out_valid}, 64'd0);

        // Full-rate stream to channel 1.
        out_ready = 4'b1111;
        in_sel    = 2'd1;
        for (int k = 1; k <= 16; k++) begin
            in_valid = 1'b1;
            in_data  = 16'(k);
            #1;
            chk($sformatf("rate_in_ready_%0d", k), {63'd0, in_ready}, 64'd1);
            tick();
            chk($sformatf("rate_data_%0d", k), {48'd0, out_data[31:16]}, 64'(k));
        end
        in_valid = 1'b0;
        tick();
        chk("rate_idle", {60'd0, out_valid}, 64'd0);

        // Broadcast blocked by stalled channel 3, then released.
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_data   = 16'h0333;
        in_sel    = 2'd3;
        tick();
        chk("bc_pre_valid", {60'd0, out_valid}, 64'h8);
        in_bcast = 1'b1;
        in_data  = 16'h1234;
        #1;
        chk("bc_blocked", {63'd0, in_ready}, 64'd0);
        tick();
        chk("bc_no_load", {60'd0, out_valid}, 64'h8);
        chk("bc_ch3_hold", {48'd0, out_data[63:48]}, 64'h0333);
        out_ready = 4'b1000;
        #1;
        chk("bc_ready", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        in_bcast = 1'b0;
        chk("bc_valid", {60'd0, out_valid}, 64'hF);
        for (int i = 0; i < 4; i++)
            chk($sformatf("bc_data%0d", i), {48'd0, out_data[i*16 +: 16]}, 64'h1234);
        out_ready = 4'b1111;
        tick();
        chk("bc_drained", {60'd0, out_valid}, 64'd0);

        // Channel independence: stalled channel 0 does not block channel 1.
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_data   = 16'h00A0;
        in_sel    = 2'd0;
        tick();
        in_data = 16'h00B1;
        in_sel  = 2'd1;
        #1;
        chk("indep_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        chk("indep_valid", {60'd0, out_valid}, 64'h3);
        in_data = 16'h00C2;
        in_sel  = 2'd2;
        tick();
        in_valid = 1'b0;
        chk("three_valid", {60'd0, out_valid}, 64'h7);

        // Out-of-range drop on the 3-channel instance.
        in_valid3 = 1'b1;
        in_data   = 16'h0011;
        in_sel    = 2'd0;
        tick();
        in_data = 16'h00AA;
        in_sel  = 2'd3;
        #1;
        chk("drop_in_ready", {63'd0, in_ready3}, 64'd1);
        chk("drop_pre", {63'd0, drop3}, 64'd0);
        tick();
        in_valid3 = 1'b0;
        chk("drop_pulse", {63'd0, drop3}, 64'd1);
        chk("drop_valid", {61'd0, out_valid3}, 64'h1);
        chk("drop_ch0", {48'd0, out_data3[15:0]}, 64'h0011);
        tick();
        chk("drop_clear", {63'd0, drop3}, 64'd0);
        chk("drop_valid2", {61'd0, out_valid3}, 64'h1);

        // Asynchronous reset pulse between edges discards everything.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {60'd0, out_valid}, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_valid3", {61'd0, out_valid3}, 64'd0);
        sb.delete();
        rst_n     = 1'b1;
        out_ready = 4'b1111;
        tick();
        chk("arst_after1", {60'd0, out_valid}, 64'd0);
        tick();
        chk("arst_after2", {60'd0, out_valid}, 64'd0);
        tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
